// File: rtl/divu_seq.sv
// Multi-cycle unsigned divider for the EX stage: radix-2 restoring divide,
// one quotient bit per cycle, stalling the pipeline until the result is ready.
module divu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_sub;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] dq_next;
  logic             take;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    r_shift = {r_q[WIDTH-1:0], dq_q[WIDTH-1]};
    r_sub   = r_shift - {1'b0, dvs_q};
    take    = (r_shift >= {1'b0, dvs_q});
    r_next  = take ? r_sub : r_shift;
    dq_next = {dq_q[WIDTH-2:0], take};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    r_d     = r_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              state_d = RUN;
              busy_d  = 1'b1;
              dq_d    = dividend;
              dvs_d   = divisor;
              r_d     = '0;
              cnt_d   = CW'(WIDTH - 1);
              dbz_d   = 1'b0;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
              quo_d   = '1;
              rem_d   = dividend;
              dbz_d   = 1'b1;
            end
          end
        end
        RUN: begin
          r_d   = r_next;
          dq_d  = dq_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            quo_d   = dq_next;
            rem_d   = r_next[WIDTH-1:0];
          end else begin
            busy_d = 1'b1;
          end
        end
        // DONE never samples start: the divide that produced it leaves EX now.
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign stall       = ((state_q == IDLE) && start && !flush) || (state_q == RUN);
  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divu_seq.sv
// Scoreboard bench for divu_seq: expected results come from plain / and %
// arithmetic and are checked by a monitor whenever done is presented.
module tb_divu_seq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             flush;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  divu_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .dividend(dividend), .divisor(divisor),
    .stall(stall), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int asserts = 0;
  int fails = 0;
  logic [WIDTH-1:0] lastQ = '0;
  logic [WIDTH-1:0] lastR = '0;

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] req);
    asserts++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s actual=0x%h required=0x%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Result and arrival cycle of a divide whose start is sampled in cycle c.
  function automatic exp_t refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input int c);
    exp_t e;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1; e.cyc = c + 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.cyc = c + WIDTH + 1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        asserts++;
        fails++;
        $display("[TB] FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("quotient", quotient, e.q);
        checkOutput("remainder", remainder, e.r);
        checkOutput("div_by_zero", div_by_zero, e.dbz);
        checkOutput("done_cycle", cyc, e.cyc);
        lastQ = e.q;
        lastR = e.r;
      end
    end
  end

  // Issue one divide, then scramble operands and track stall/busy until idle.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bit nz;
    int lat;
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    sb.push_back(refModel(a, b, cyc));
    nz = (b != 0);
    lat = nz ? WIDTH + 1 : 1;
    #1 checkOutput("stall_issue", stall, 1);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      start = 1'b0;
      dividend = $urandom;
      divisor = $urandom;
      #1;
      checkOutput("stall", stall, (nz && k <= WIDTH));
      checkOutput("busy", busy, (nz && k <= WIDTH));
    end
    checkOutput("result_arrived", sb.size(), 0);
  endtask

  task automatic resetMidRun;
    @(negedge clk);
    start = 1'b1;
    dividend = 100;
    divisor = 7;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 10) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    lastQ = '0;
    lastR = '0;
    #1;
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_quotient", quotient, 0);
    checkOutput("rst_remainder", remainder, 0);
  endtask

  task automatic flushMidRun;
    @(negedge clk);
    start = 1'b1;
    dividend = 32'h1234_5678;
    divisor = 32'h0000_1234;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    #1 checkOutput("flush_stall_run", stall, 1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("flush_busy", busy, 0);
    checkOutput("flush_stall", stall, 0);
    checkOutput("flush_quotient", quotient, lastQ);
    checkOutput("flush_remainder", remainder, lastR);
  endtask

  // start stays high through DONE; only the cycle after DONE may restart.
  task automatic backToBack;
    @(negedge clk);
    start = 1'b1;
    dividend = 100;
    divisor = 7;
    sb.push_back(refModel(100, 7, cyc));
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k < 34) begin
        dividend = $urandom;
        divisor = $urandom | 1;
      end else begin
        dividend = 9;
        divisor = 4;
        sb.push_back(refModel(9, 4, cyc));
      end
      #1;
      if (k == 33) checkOutput("b2b_stall_done", stall, 0);
      if (k == 34) checkOutput("b2b_stall_restart", stall, 1);
    end
    for (int k = 35; k <= 68; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1 checkOutput("b2b_results_arrived", sb.size(), 0);
  endtask

  initial begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    rst = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_stall", stall, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_quotient", quotient, 0);
    checkOutput("reset_remainder", remainder, 0);
    checkOutput("reset_dbz", div_by_zero, 0);

    applyStimulus(100, 7);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001);
    applyStimulus(32'h0000_0005, 32'hFFFF_FFFF);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(1234, 0);
    resetMidRun();
    applyStimulus(77, 5);
    flushMidRun();
    applyStimulus(32'h8000_0000, 3);
    backToBack();

    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 1000);
        2:       b = '0;
        default: b = a >> $urandom_range(0, WIDTH - 1);
      endcase
      applyStimulus(a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/divu_seq.md
Name: divu_seq

Overview:
- Multi-cycle sequencer and iterative datapath for the unsigned divide instruction (decoded as ALU_DIVU); sits beside the ALU in the execute stage.
- Captures operands when a divide occupies EX and runs a radix-2 restoring divide, one quotient bit per cycle.
- Holds a stall on the pipeline until the result is ready, then presents quotient and remainder for one cycle so EX can forward/write back.

Parameters:
WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  level: divide instruction present in EX (alu_opcode == ALU_DIVU and not a bubble)
flush  input  1  abort current operation (branch/jump squash of EX)
dividend  input  WIDTH  rs operand (alu_op_x)
divisor  input  WIDTH  rt operand (alu_op_y)
stall  output  1  hold IF/ID/EX; combinational from state and start
busy  output  1  registered, high in RUN
done  output  1  registered, result valid this cycle
quotient  output  WIDTH  result quotient
remainder  output  WIDTH  result remainder
div_by_zero  output  1  qualifies done; divisor was 0

Behaviour:
- Reset (rst high at posedge): state=IDLE, counter=0, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, all internal operand registers 0. rst has priority over flush and start.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1, flush=0, divisor!=0: latch dividend and divisor, clear partial remainder (WIDTH+1 bits), counter=WIDTH-1, go to RUN.
  - start=1, flush=0, divisor==0: go to DONE with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - r' = {r[WIDTH-1:0], dq[WIDTH-1]}, where dq is the shifting dividend/quotient register.
  - If r' >= divisor: r = r' - divisor and shift 1 into the dq LSB; else r = r' and shift 0.
  - Compare and subtract are done at WIDTH+1 bits.
  - counter decrements; when counter==0 at the edge, go to DONE.
  - start is ignored while in RUN.
- DONE: lasts exactly one cycle. done=1; quotient=dq; remainder=r[WIDTH-1:0]; div_by_zero=0 unless set on the zero-divisor path. Always return to IDLE. start is not sampled in DONE, because the same instruction leaves EX at this edge.
- Outputs quotient, remainder and div_by_zero hold their values after DONE until the next capture or reset. done is high only in DONE.
- stall = (state==IDLE & start & ~flush) | (state==RUN). stall is low in DONE so the pipeline advances on the edge that ends DONE.
- Latency: with start sampled in cycle 0 and divisor nonzero, RUN occupies cycles 1..WIDTH, DONE is cycle WIDTH+1, and stall is high in cycles 0..WIDTH (WIDTH+1 cycles). Zero divisor: DONE in cycle 1, stall high only in cycle 0.
- flush in any state: next state IDLE, busy=0, done=0. Result registers are not updated. stall is 0 in the flush cycle only if state is IDLE (RUN stalls combinationally until the edge).
- Back-to-back divides: the second divide enters EX in cycle WIDTH+2, finds IDLE and restarts. There are no idle penalty cycles beyond that.
- Operands are sampled only on the IDLE→RUN edge. Later changes on dividend/divisor have no effect.
- Full-width cases:
  - dividend < divisor: quotient=0, remainder=dividend.
  - divisor=1: quotient=dividend, remainder=0.
  - dividend=divisor={WIDTH{1}}: quotient=1, remainder=0.

Test Plan:
- Reset mid-RUN (rst at cycle 10 of a divide) → next cycle state IDLE, stall=0, busy=0, done=0, quotient=0, remainder=0.
- start with 100/7 at cycle 0 → stall high cycles 0..32, done=1 in cycle 33 with quotient=14, remainder=2, div_by_zero=0. Operands changed during RUN do not affect the result.
- 0xFFFFFFFF/0x00000001 and 0x00000005/0xFFFFFFFF → quotient 0xFFFFFFFF/rem 0 and quotient 0/rem 5 respectively, both at cycle 33.
- 1234/0 → done in cycle 1 with quotient=0xFFFFFFFF, remainder=1234, div_by_zero=1; stall high only in cycle 0.
- flush at cycle 15 of a RUN → IDLE at cycle 16, no done pulse, quotient/remainder keep the prior result. A new start at cycle 17 (0x80000000/3) → done at cycle 50, quotient=0x2AAAAAAA, remainder=2.
- Back-to-back 100/7 then 9/4 (start held through DONE, then a new start at cycle 34) → two done pulses at cycles 33 and 67 with (14,2) and (2,1). No extra DONE from start held during DONE.
